// File: rtl/bcd_pkg.sv
// Shared types for the BCD up counter: digit type, digit limit and control states.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } bcd_up_state_t;

endpackage

// File: rtl/bcd_up_counter_digit.sv
// One BCD digit: synchronous reset to 0, active-low preset load, 0..9 rollover on enable.
module up_counter_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       loadN,
  input  logic       enable,
  input  bcd_digit_t datain,
  output bcd_digit_t count,
  output logic       carry
);

  bcd_digit_t r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (!loadN) begin
      r_count <= datain;
    end else if (enable) begin
      r_count <= (r_count == BCD_NINE) ? '0 : r_count + 4'd1;
    end
  end

  assign count = r_count;
  assign carry = (r_count == BCD_NINE);

endmodule

// File: rtl/bcd_up_counter.sv
// Two-digit BCD up counter from 00 to a programmable maximum, with preset load,
// ANDed enables and wrap-or-halt behaviour at the terminal value.
module bcd_up_counter
  import bcd_pkg::*;
#(
  parameter bcd_digit_t PRESET_L = 4'h0,
  parameter bcd_digit_t PRESET_H = 4'h0,
  parameter bcd_digit_t MAX_L    = 4'h9,
  parameter bcd_digit_t MAX_H    = 4'h9,
  parameter bit         WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       loadN,
  input  logic       enable1,
  input  logic       enable2,
  output logic [3:0] countL,
  output logic [3:0] countH,
  output logic       tc,
  output logic       wrap_pulse,
  output logic       halted
);

  if (PRESET_L > BCD_NINE || PRESET_H > BCD_NINE || MAX_L > BCD_NINE ||
      MAX_H > BCD_NINE || {PRESET_H, PRESET_L} > {MAX_H, MAX_L}) begin : g_bad_params
    $error("bcd_up_counter: digits must be 0..9 and PRESET must not exceed MAX");
  end

  bcd_up_state_t r_state;
  logic          r_wrap_pulse;
  bcd_digit_t    w_count_lo;
  bcd_digit_t    w_count_hi;
  logic          w_carry_lo;
  logic          w_carry_hi;
  logic          w_at_max;
  logic          w_step;
  logic          w_en_lo;
  logic          w_en_hi;
  logic          w_clear;
  logic          w_digit_reset;

  assign w_at_max = (w_count_hi == MAX_H) && (w_count_lo == MAX_L);
  assign w_step   = enable1 & enable2 & (r_state == RUN);
  assign w_en_lo  = w_step & ~w_at_max;
  assign w_en_hi  = w_en_lo & w_carry_lo;

  // Wrap clears both digits through their reset; gated by loadN so a load still wins.
  assign w_clear       = w_step & w_at_max & WRAP & loadN;
  assign w_digit_reset = reset | w_clear;

  up_counter_digit u_digit_lo (
    .clk    (clk),
    .reset  (w_digit_reset),
    .loadN  (loadN),
    .enable (w_en_lo),
    .datain (PRESET_L),
    .count  (w_count_lo),
    .carry  (w_carry_lo)
  );

  up_counter_digit u_digit_hi (
    .clk    (clk),
    .reset  (w_digit_reset),
    .loadN  (loadN),
    .enable (w_en_hi),
    .datain (PRESET_H),
    .count  (w_count_hi),
    .carry  (w_carry_hi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_wrap_pulse <= 1'b0;
    end else if (!loadN) begin
      r_state      <= RUN;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_wrap_pulse <= w_step & w_at_max;
      if (w_step && w_at_max && !WRAP) begin
        r_state <= HALT;
      end
    end
  end

  assign countL     = w_count_lo;
  assign countH     = w_count_hi;
  assign tc         = w_at_max;
  assign wrap_pulse = r_wrap_pulse;
  assign halted     = (r_state == HALT);

  logic w_unused;
  assign w_unused = w_carry_hi;

endmodule
